keccak_rho_seq: RTL and testbench

KECCAK_RHO_SEQ -- requirements
Module: keccak_rho_seq

---
 rtl/keccak_pkg.sv | 18 +
 rtl/rho_lane_rot.sv | 13 +
 rtl/keccak_rho_seq.sv | 83 ++++++++
 tb/tb_keccak_rho_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// keccak_pkg: rho offset table, lane indexing, FSM state type and legal-parameter checks for the rho sequencer
package keccak_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} rhoState_t;
  localparam int RHO_OFFSETS [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                                      41, 45, 15, 21, 8, 18, 2, 61, 56, 14};
  function automatic int laneIdx(input int x, input int y);
    return 5 * y + x;
  endfunction
  function automatic int rhoOffset(input logic [4:0] idx, input int laneW);
    return RHO_OFFSETS[idx] % laneW;
  endfunction
  function automatic bit legalLaneW(input int w);
    return w == 8 || w == 16 || w == 32 || w == 64;
  endfunction
  function automatic bit legalLanesPerCyc(input int n);
    return n == 1 || n == 5 || n == 25;
  endfunction
endpackage

// File: rtl/rho_lane_rot.sv
// rho_lane_rot: combinational lane rotator; laneIn rotated by offset, left when inverse=0, right when inverse=1, onto laneOut
module rho_lane_rot #(
  parameter int LANE_W = 64
) (
  input  logic [LANE_W-1:0]         laneIn,
  input  logic [$clog2(LANE_W)-1:0] offset,
  input  logic                      inverse,
  output logic [LANE_W-1:0]         laneOut
);
  logic [2*LANE_W-1:0] dbl;
  assign dbl = {laneIn, laneIn};
  assign laneOut = inverse ? dbl[int'(offset) +: LANE_W] : dbl[LANE_W - int'(offset) +: LANE_W];
endmodule

// File: rtl/keccak_rho_seq.sv
// keccak_rho_seq: sequential Keccak rho / inverse rho; valid/ready state in (inValid/inReady/inMode/inData), valid/ready state out (outValid/outReady/outData)
module keccak_rho_seq
  import keccak_pkg::*;
#(
  parameter int LANE_W        = 64,
  parameter int LANES_PER_CYC = 1
) (
  input  logic                  inClk,
  input  logic                  inRstN,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic                  inMode,
  input  logic [25*LANE_W-1:0]  inData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [25*LANE_W-1:0]  outData
);
  localparam int NGRP  = 25 / LANES_PER_CYC;
  localparam int OFS_W = $clog2(LANE_W);
  if (!legalLaneW(LANE_W)) begin : gBadLaneW
    $error("keccak_rho_seq: LANE_W must be 8, 16, 32 or 64");
  end
  if (!legalLanesPerCyc(LANES_PER_CYC)) begin : gBadLanesPerCyc
    $error("keccak_rho_seq: LANES_PER_CYC must be 1, 5 or 25");
  end
  rhoState_t fsm, fsmNext;
  logic [4:0] grp, grpNext;
  logic modeQ, modeNext;
  logic [25*LANE_W-1:0] stReg, stNext, rotState;
  logic [4:0] laneSel [LANES_PER_CYC];
  logic [LANE_W-1:0] rotOut [LANES_PER_CYC];
  logic accept, lastGrp;
  genvar g;
  for (g = 0; g < LANES_PER_CYC; g++) begin : gRot
    assign laneSel[g] = 5'(int'(grp) * LANES_PER_CYC + g);
    rho_lane_rot #(.LANE_W(LANE_W)) uRot (
      .laneIn (stReg[int'(laneSel[g]) * LANE_W +: LANE_W]),
      .offset (OFS_W'(rhoOffset(laneSel[g], LANE_W))),
      .inverse(modeQ),
      .laneOut(rotOut[g])
    );
  end
  always_comb begin
    rotState = stReg;
    for (int i = 0; i < LANES_PER_CYC; i++) rotState[int'(laneSel[i]) * LANE_W +: LANE_W] = rotOut[i];
  end
  assign lastGrp  = grp == 5'(NGRP - 1);
  assign inReady  = fsm == IDLE || (fsm == DONE && outReady);
  assign accept   = inValid && inReady;
  assign outValid = fsm == DONE;
  assign outData  = stReg;
  always_comb begin
    fsmNext  = fsm;
    grpNext  = grp;
    modeNext = modeQ;
    stNext   = stReg;
    if (accept) begin
      fsmNext  = BUSY;
      grpNext  = '0;
      modeNext = inMode;
      stNext   = inData;
    end else if (fsm == BUSY) begin
      stNext  = rotState;
      grpNext = lastGrp ? 5'd0 : grp + 5'd1;
      fsmNext = lastGrp ? DONE : BUSY;
    end else if (fsm == DONE && outReady) begin
      fsmNext = IDLE;
    end
  end
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      fsm   <= IDLE;
      grp   <= '0;
      modeQ <= 1'b0;
      stReg <= '0;
    end else begin
      fsm   <= fsmNext;
      grp   <= grpNext;
      modeQ <= modeNext;
      stReg <= stNext;
    end
  end
endmodule

// File: tb/tb_keccak_rho_seq.sv
// tb_keccak_rho_seq: directed checks of keccak_rho_seq across lane widths and group sizes
module tb_keccak_rho_seq;
  localparam int OFFS [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                               41, 45, 15, 21, 8, 18, 2, 61, 56, 14};
  logic clk = 1'b0, rstN = 1'b0;
  always #5 clk = ~clk;
  logic inValid = 1'b0, inMode = 1'b0, outReady = 1'b0;
  logic [1599:0] inData = '0;
  logic aInReady, aOutValid, cInReady, cOutValid, dInReady, dOutValid;
  logic [1599:0] aOutData, cOutData, dOutData;
  logic bInValid = 1'b0, bInMode = 1'b0, bOutReady = 1'b0, bInReady, bOutValid;
  logic [199:0] bInData = '0, bOutData;
  int errs = 0, checks = 0;

  keccak_rho_seq #(.LANE_W(64), .LANES_PER_CYC(1)) dutA (
    .inClk(clk), .inRstN(rstN), .inValid(inValid), .inReady(aInReady), .inMode(inMode),
    .inData(inData), .outValid(aOutValid), .outReady(outReady), .outData(aOutData));
  keccak_rho_seq #(.LANE_W(64), .LANES_PER_CYC(5)) dutC (
    .inClk(clk), .inRstN(rstN), .inValid(inValid), .inReady(cInReady), .inMode(inMode),
    .inData(inData), .outValid(cOutValid), .outReady(outReady), .outData(cOutData));
  keccak_rho_seq #(.LANE_W(64), .LANES_PER_CYC(25)) dutD (
    .inClk(clk), .inRstN(rstN), .inValid(inValid), .inReady(dInReady), .inMode(inMode),
    .inData(inData), .outValid(dOutValid), .outReady(outReady), .outData(dOutData));
  keccak_rho_seq #(.LANE_W(8), .LANES_PER_CYC(1)) dutB (
    .inClk(clk), .inRstN(rstN), .inValid(bInValid), .inReady(bInReady), .inMode(bInMode),
    .inData(bInData), .outValid(bOutValid), .outReady(bOutReady), .outData(bOutData));

  function automatic logic [1599:0] rhoRef(input logic [1599:0] s, input logic m, input int w);
    logic [63:0] l, r;
    int off;
    rhoRef = '0;
    for (int i = 0; i < 25; i++) begin
      off = OFFS[i] % w;
      l = '0;
      r = '0;
      for (int b = 0; b < w; b++) l[b] = s[i*w+b];
      for (int b = 0; b < w; b++) if (m) r[b] = l[(b+off)%w]; else r[(b+off)%w] = l[b];
      for (int b = 0; b < w; b++) rhoRef[i*w+b] = r[b];
    end
  endfunction

  function automatic logic [1599:0] rnd();
    for (int i = 0; i < 50; i++) rnd[i*32 +: 32] = $urandom();
  endfunction

  task automatic waitDone(input int start, output int la, output int lc, output int ld);
    int cnt = start;
    la = -1; lc = -1; ld = -1;
    while ((la < 0 || lc < 0 || ld < 0) && cnt < 60) begin
      @(negedge clk);
      cnt++;
      inValid = 1'b0;
      if (aOutValid && la < 0) la = cnt - 1;
      if (cOutValid && lc < 0) lc = cnt - 1;
      if (dOutValid && ld < 0) ld = cnt - 1;
    end
  endtask

  task automatic releaseOut();
    @(negedge clk) outReady = 1'b1;
    @(negedge clk) outReady = 1'b0;
  endtask

  task automatic runTx(input logic [1599:0] d, input logic m, output logic [1599:0] ra,
                       output logic [1599:0] rc, output logic [1599:0] rd,
                       output int la, output int lc, output int ld);
    @(negedge clk);
    inData = d; inMode = m; inValid = 1'b1; outReady = 1'b0;
    @(posedge clk);
    waitDone(0, la, lc, ld);
    ra = aOutData; rc = cOutData; rd = dOutData;
    releaseOut();
  endtask

  task automatic checkLat(input string name, input int la, input int lc, input int ld);
    checks++; if (la != 25) begin errs++; $display("FAIL %s latency x1: got %0d want 25", name, la); end
    checks++; if (lc != 5)  begin errs++; $display("FAIL %s latency x5: got %0d want 5", name, lc); end
    checks++; if (ld != 1)  begin errs++; $display("FAIL %s latency x25: got %0d want 1", name, ld); end
  endtask

  task automatic checkAll(input string name, input logic [1599:0] ra, input logic [1599:0] rc,
                          input logic [1599:0] rd, input logic [1599:0] exp);
    checks++; if (ra !== exp) begin errs++; $display("FAIL %s x1: got %h want %h", name, ra, exp); end
    checks++; if (rc !== exp) begin errs++; $display("FAIL %s x5: got %h want %h", name, rc, exp); end
    checks++; if (rd !== exp) begin errs++; $display("FAIL %s x25: got %h want %h", name, rd, exp); end
  endtask

  task automatic test_reset();
    logic [1599:0] d, exp;
    int la, lc, ld;
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({aOutValid, cOutValid, dOutValid, bOutValid} !== 4'b0000) begin errs++; $display("FAIL reset outValid: got %b want 0000", {aOutValid, cOutValid, dOutValid, bOutValid}); end
    checks++; if ({aInReady, cInReady, dInReady, bInReady} !== 4'b1111) begin errs++; $display("FAIL reset inReady: got %b want 1111", {aInReady, cInReady, dInReady, bInReady}); end
    checks++; if (aOutData !== '0 || cOutData !== '0 || dOutData !== '0 || bOutData !== '0) begin errs++; $display("FAIL reset outData: got nonzero want 0"); end
    d = '0; d[192] = 1'b1;
    exp = '0; exp[220] = 1'b1;
    rstN = 1'b1; inData = d; inMode = 1'b0; inValid = 1'b1; outReady = 1'b0;
    @(posedge clk);
    waitDone(0, la, lc, ld);
    checkLat("first_edge", la, lc, ld);
    checkAll("first_edge lane3", aOutData, cOutData, dOutData, exp);
    releaseOut();
  endtask

  task automatic test_single_lane();
    logic [1599:0] d, exp, ra, rc, rd;
    int la, lc, ld;
    d = '0; d[64] = 1'b1;
    runTx(d, 1'b0, ra, rc, rd, la, lc, ld);
    checkLat("lane1_rho", la, lc, ld);
    exp = '0; exp[65] = 1'b1;
    checkAll("lane1_rho", ra, rc, rd, exp);
    runTx(d, 1'b1, ra, rc, rd, la, lc, ld);
    exp = '0; exp[127] = 1'b1;
    checkAll("lane1_inv", ra, rc, rd, exp);
  endtask

  task automatic runB(input logic [199:0] d, input logic m, output logic [199:0] r, output int lat);
    int cnt = 0;
    @(negedge clk);
    bInData = d; bInMode = m; bInValid = 1'b1; bOutReady = 1'b0;
    @(posedge clk);
    lat = -1;
    while (lat < 0 && cnt < 60) begin
      @(negedge clk);
      cnt++;
      bInValid = 1'b0;
      if (bOutValid) lat = cnt - 1;
    end
    r = bOutData;
    @(negedge clk) bOutReady = 1'b1;
    @(negedge clk) bOutReady = 1'b0;
  endtask

  task automatic test_lane8();
    logic [199:0] d, r, exp;
    logic [1599:0] full;
    int lat;
    d = '0; d[16] = 1'b1;
    runB(d, 1'b0, r, lat);
    checks++; if (lat != 25) begin errs++; $display("FAIL w8 latency: got %0d want 25", lat); end
    exp = '0; exp[22] = 1'b1;
    checks++; if (r !== exp) begin errs++; $display("FAIL w8 lane2 rho: got %h want %h", r, exp); end
    runB(d, 1'b1, r, lat);
    exp = '0; exp[18] = 1'b1;
    checks++; if (r !== exp) begin errs++; $display("FAIL w8 lane2 inv: got %h want %h", r, exp); end
    runB({200{1'b1}}, 1'b0, r, lat);
    checks++; if (r !== {200{1'b1}}) begin errs++; $display("FAIL w8 all_ones: got %h want all ones", r); end
    full = rnd();
    d = full[199:0];
    runB(d, 1'b0, r, lat);
    full = rhoRef({1400'b0, d}, 1'b0, 8);
    checks++; if (r !== full[199:0]) begin errs++; $display("FAIL w8 random: got %h want %h", r, full[199:0]); end
  endtask

  task automatic test_roundtrip();
    logic [1599:0] v, ra, rc, rd, fa, fc, fd;
    int la, lc, ld;
    for (int k = 0; k < 2; k++) begin
      v = rnd();
      runTx(v, 1'b0, fa, fc, fd, la, lc, ld);
      checkAll("random_rho", fa, fc, fd, rhoRef(v, 1'b0, 64));
      runTx(fa, 1'b1, ra, rc, rd, la, lc, ld);
      checkLat("random_inv", la, lc, ld);
      checkAll("roundtrip", ra, rc, rd, v);
    end
  endtask

  task automatic test_stall();
    logic [1599:0] v, v2, hold, exp;
    int la, lc, ld;
    v = rnd();
    @(negedge clk);
    inData = v; inMode = 1'b0; inValid = 1'b1; outReady = 1'b0;
    @(posedge clk);
    waitDone(0, la, lc, ld);
    hold = aOutData;
    exp = rhoRef(v, 1'b0, 64);
    checks++; if (hold !== exp) begin errs++; $display("FAIL stall result: got %h want %h", hold, exp); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (aOutValid !== 1'b1 || aOutData !== hold || aInReady !== 1'b0) begin
        errs++; $display("FAIL stall hold cycle %0d: outValid=%b inReady=%b data_same=%b want 1 0 1", i, aOutValid, aInReady, aOutData === hold);
      end
    end
    v2 = rnd();
    inData = v2; inMode = 1'b1; inValid = 1'b1; outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0; outReady = 1'b0;
    checks++; if ({aOutValid, cOutValid, dOutValid} !== 3'b000) begin errs++; $display("FAIL b2b outValid drop: got %b want 000", {aOutValid, cOutValid, dOutValid}); end
    checks++; if (aInReady !== 1'b0) begin errs++; $display("FAIL b2b busy inReady: got %b want 0", aInReady); end
    waitDone(1, la, lc, ld);
    checkLat("b2b", la, lc, ld);
    checkAll("b2b inv", aOutData, cOutData, dOutData, rhoRef(v2, 1'b1, 64));
    releaseOut();
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    @(negedge clk);
    inData = rnd(); inMode = 1'b0; inValid = 1'b1; outReady = 1'b0;
    @(posedge clk);
    @(negedge clk) inValid = 1'b0;
    repeat (12) @(posedge clk);
    #1 rstN = 1'b0;
    #1;
    checks++; if ({aOutValid, cOutValid, dOutValid} !== 3'b000) begin errs++; $display("FAIL abort outValid: got %b want 000", {aOutValid, cOutValid, dOutValid}); end
    checks++; if (aInReady !== 1'b1) begin errs++; $display("FAIL abort inReady: got %b want 1", aInReady); end
    checks++; if (aOutData !== '0) begin errs++; $display("FAIL abort outData: got %h want 0", aOutData); end
    @(negedge clk) rstN = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (aOutValid || cOutValid || dOutValid) seen++;
    end
    checks++; if (seen != 0) begin errs++; $display("FAIL abort stray output: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [1599:0] vec [100];
    logic vm [100];
    int sent = 0, recv = 0, cyc = 0;
    for (int i = 0; i < 100; i++) begin
      vec[i] = rnd();
      vm[i] = 1'(i % 2);
    end
    @(negedge clk);
    outReady = 1'b1;
    while (recv < 100 && cyc < 500) begin
      cyc++;
      if (dOutValid) begin
        checks++;
        if (dOutData !== rhoRef(vec[recv], vm[recv], 64)) begin errs++; $display("FAIL stream item %0d: got %h", recv, dOutData); end
        recv++;
      end
      if (sent < 100) begin
        inData = vec[sent]; inMode = vm[sent]; inValid = 1'b1;
        if (dInReady) sent++;
      end else inValid = 1'b0;
      @(negedge clk);
    end
    checks++; if (recv != 100) begin errs++; $display("FAIL stream count: got %0d want 100", recv); end
    checks++; if (cyc != 201) begin errs++; $display("FAIL stream throughput cycles: got %0d want 201", cyc); end
    inValid = 1'b0; outReady = 1'b0; rstN = 1'b0;
    @(negedge clk) rstN = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_lane();
    test_lane8();
    test_roundtrip();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
